// File: rtl/exec_controller_pkg.sv
// Shared types and constants for the program-sequencing execution controller.
// Holds the FSM encoding, opcode limits, watchdog limit and instruction field slices.
package exec_controller_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LATCH  = 3'd2,
      CLEAR  = 3'd3,
      EXEC   = 3'd4,
      RETIRE = 3'd5,
      FINISH = 3'd6
   } state_t;

   localparam logic [3:0] OP_GCD         = 4'hB;
   localparam logic [3:0] OP_MAX_VALID   = 4'hB;
   localparam logic [7:0] WATCHDOG_LIMIT = 8'd255;

   // Instruction word layout: {opcode, a, b}
   localparam int OPC_MSB = 19;
   localparam int OPC_LSB = 16;
   localparam int A_MSB   = 15;
   localparam int A_LSB   = 8;
   localparam int B_MSB   = 7;
   localparam int B_LSB   = 0;

   function automatic logic opcode_valid(input logic [3:0] op);
      return op <= OP_MAX_VALID;
   endfunction

endpackage

// File: rtl/exec_controller_if.sv
// Instruction-memory and datapath bus between the controller (master) and
// the memory/datapath side (slave).
interface exec_controller_if #(
   parameter int WIDTH     = 16,
   parameter int INSTR_LEN = 20,
   parameter int ADDR      = 5
);
   logic [ADDR-1:0]      instr_addr;
   logic [INSTR_LEN-1:0] instr_data;
   logic [3:0]           opcode;
   logic [7:0]           a;
   logic [7:0]           b;
   logic                 go;
   logic                 enable;
   logic                 invalid_opcode;
   logic [WIDTH-1:0]     dp_result;
   logic                 dp_done;

   // go clears the datapath, then exactly one of enable / invalid_opcode is
   // held until dp_done; the three controls are mutually exclusive.
   modport master (
      output instr_addr, opcode, a, b, go, enable, invalid_opcode,
      input  instr_data, dp_result, dp_done
   );

   modport slave (
      input  instr_addr, opcode, a, b, go, enable, invalid_opcode,
      output instr_data, dp_result, dp_done
   );
endinterface

// File: rtl/exec_controller.sv
// Runs a program of num_instr instructions from address 0 through an external
// datapath, retiring one result per instruction, with an EXEC watchdog.
module exec_controller
   import exec_controller_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int INSTR_LEN = 20,
   parameter int ADDR      = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR:0]     num_instr,
   exec_controller_if.master bus,
   output logic [WIDTH-1:0]  result_out,
   output logic [ADDR-1:0]   result_idx,
   output logic              result_valid,
   output logic              result_invalid,
   output logic              busy,
   output logic              done,
   output logic              error,
   output state_t            state_dbg
);

   state_t               state;
   logic [ADDR-1:0]      pc;
   logic [ADDR-1:0]      last_pc;
   logic [7:0]           wd;
   logic                 instr_invalid;
   logic [INSTR_LEN-1:0] instr_word;

   assign instr_word = bus.instr_data;
   assign state_dbg  = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state              <= IDLE;
         pc                 <= '0;
         last_pc            <= '0;
         wd                 <= '0;
         instr_invalid      <= 1'b0;
         bus.instr_addr     <= '0;
         bus.opcode         <= '0;
         bus.a              <= '0;
         bus.b              <= '0;
         bus.go             <= 1'b0;
         bus.enable         <= 1'b0;
         bus.invalid_opcode <= 1'b0;
         result_out         <= '0;
         result_idx         <= '0;
         result_valid       <= 1'b0;
         result_invalid     <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
         error              <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  error <= 1'b0;
                  if (num_instr == '0) begin
                     done  <= 1'b1;
                     state <= FINISH;
                  end else begin
                     last_pc        <= ADDR'(num_instr - 1'b1);
                     pc             <= '0;
                     bus.instr_addr <= '0;
                     busy           <= 1'b1;
                     state          <= FETCH;
                  end
               end
            end
            FETCH: state <= LATCH;
            LATCH: begin
               bus.opcode    <= instr_word[OPC_MSB:OPC_LSB];
               bus.a         <= instr_word[A_MSB:A_LSB];
               bus.b         <= instr_word[B_MSB:B_LSB];
               instr_invalid <= !opcode_valid(instr_word[OPC_MSB:OPC_LSB]);
               bus.go        <= 1'b1;
               state         <= CLEAR;
            end
            CLEAR: begin
               bus.go             <= 1'b0;
               bus.enable         <= !instr_invalid;
               bus.invalid_opcode <= instr_invalid;
               wd                 <= '0;
               state              <= EXEC;
            end
            EXEC: begin
               wd <= wd + 8'd1;
               if (bus.dp_done) begin
                  bus.enable         <= 1'b0;
                  bus.invalid_opcode <= 1'b0;
                  result_valid       <= 1'b1;
                  result_out         <= bus.dp_result;
                  result_idx         <= pc;
                  result_invalid     <= instr_invalid;
                  state              <= RETIRE;
               end else if (wd == WATCHDOG_LIMIT - 8'd1) begin
                  // Datapath never answered: abandon the run without retiring.
                  bus.enable         <= 1'b0;
                  bus.invalid_opcode <= 1'b0;
                  error              <= 1'b1;
                  busy               <= 1'b0;
                  done               <= 1'b1;
                  state              <= FINISH;
               end
            end
            RETIRE: begin
               result_valid <= 1'b0;
               if (pc == last_pc) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= FINISH;
               end else begin
                  pc             <= pc + 1'b1;
                  bus.instr_addr <= pc + 1'b1;
                  state          <= FETCH;
               end
            end
            FINISH: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/exec_controller.md
EXEC_CONTROLLER -- requirements
Module: exec_controller

Interface
REQ-001 Parameter WIDTH, 16: result width.
REQ-002 Parameter INSTR_LEN, 20: instruction word {opcode[19:16], a[15:8], b[7:0]}.
REQ-003 Parameter ADDR, 5: instruction address width, 32-entry program.
REQ-004 clk  in  1: single clock, rising edge.
REQ-005 reset  in  1: asynchronous, active-high reset.
REQ-006 start  in  1: one-cycle request to run a program from address 0.
REQ-007 num_instr  in  ADDR+1: program length, 0..32, sampled on accepted start.
REQ-008 instr_addr  out  ADDR: instruction memory address; synchronous read, 1-cycle latency.
REQ-009 instr_data  in  INSTR_LEN: instruction memory read data.
REQ-010 opcode, a, b  out  4/8/8: operand bus to datapath, held from the instruction register.
REQ-011 go, enable, invalid_opcode  out  1 each: datapath controls.
REQ-012 dp_result  in  WIDTH; dp_done  in  1: datapath result and done.
REQ-013 result_out  out  WIDTH; result_idx  out  ADDR; result_valid  out  1; result_invalid  out  1: retired-result port.
REQ-014 busy  out  1; done  out  1; error  out  1: run status.

Function
REQ-015 FSM states: IDLE, FETCH, LATCH, CLEAR, EXEC, RETIRE, FINISH.
REQ-016 IDLE: busy=0; start=1 with num_instr=0 -> FINISH; start=1 with num_instr>0 -> FETCH with pc=0 and error cleared.
REQ-017 FETCH, one cycle: instr_addr=pc. LATCH, one cycle: instr_data captured into the instruction register, opcode validity decoded.
REQ-018 Valid opcodes are 0x0-0xB; 0xC-0xF are invalid.
REQ-019 CLEAR, one cycle: go=1, enable=0, invalid_opcode=0 (clears datapath done).
REQ-020 EXEC, valid opcode: enable=1, go=0; held until dp_done=1 (covers single-cycle ALU and multi-cycle GCD 0xB).
REQ-021 EXEC, invalid opcode: invalid_opcode=1, enable=0, go=0; held until dp_done=1.
REQ-022 EXEC watchdog: 8-bit counter, zeroed on EXEC entry. If it reaches 255 with dp_done=0, error=1 and the FSM goes directly to FINISH with no RETIRE.
REQ-023 EXEC exits on the first cycle dp_done=1 (dp_done sampled registered) -> RETIRE.
REQ-024 RETIRE, one cycle: result_valid=1, result_out=dp_result, result_idx=pc, result_invalid=instruction invalid flag.
REQ-025 After RETIRE: pc==num_instr-1 -> FINISH; otherwise pc+1 -> FETCH.
REQ-026 FINISH, one cycle: done=1, busy=0 -> IDLE.
REQ-027 busy=1 in FETCH..RETIRE.
REQ-028 start is ignored while busy=1 or in FINISH.
REQ-029 error is sticky until the next accepted start. result_out/result_idx hold their last value outside RETIRE.
REQ-030 go, enable and invalid_opcode are never asserted in the same cycle.
REQ-031 Per-instruction overhead is 4 cycles plus EXEC duration.

Reset
REQ-032 reset forces IDLE, pc=0, watchdog=0, and every output to 0 (instr_addr, opcode, a, b, go, enable, invalid_opcode, result_out, result_idx, result_valid, result_invalid, busy, done, error).
REQ-033 reset asserted mid-run abandons the run; no result_valid or done is produced afterwards.

Structure
REQ-034 Shared package holds: the state enum, opcode constants (OP_GCD=4'hB, OP_MAX_VALID=4'hB), WATCHDOG_LIMIT=255, and the instruction field slices.
REQ-035 Single module, no sub-modules; the top level instantiates it beside datapath.

Verification
REQ-036 Single instruction {0xB,48,18}, num_instr=1, behavioural datapath -> one RETIRE with result_out=6, result_idx=0, then done for 1 cycle.
REQ-037 Three instructions {0x0,3,5}, {0xF,1,1}, {0xB,21,14} -> result_idx 0,1,2 in order; idx1 result_out=0 with result_invalid=1; idx2 result_out=7.
REQ-038 num_instr=0, start pulse -> done exactly 2 cycles after start, no FETCH, no result_valid.
REQ-039 Stub dp_done tied 0 -> error=1 and done after 255 EXEC cycles, no result_valid; next start clears error.
REQ-040 reset pulsed during EXEC of a GCD -> all outputs 0 next cycle; subsequent start runs normally from address 0.
REQ-041 start re-pulsed while busy -> ignored, result sequence unchanged.
